// File: rtl/decode_branch.sv
`default_nettype none
// ============================================================================
// Module   : decode_branch
// Purpose  : Decode stage. Register file, branch resolution with operand
//            forwarding, and the ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module decode_branch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_in,
  input  logic [31:0] npc_in,
  input  logic        ex_wen,
  input  logic [4:0]  ex_addr,
  input  logic [31:0] ex_data,
  input  logic        wb_wen,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        cond,
  output logic [31:0] rpc,
  output logic [31:0] id_ir,
  output logic [31:0] id_npc,
  output logic [31:0] id_a,
  output logic [31:0] id_b,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dst,
  output logic        id_wen,
  output logic [15:0] taken_cnt
);

  localparam logic [5:0] c_OP_STORE = 6'b010000;
  localparam logic [5:0] c_OP_LOAD  = 6'b010001;
  localparam logic [5:0] c_OP_BEQZ  = 6'b100000;
  localparam logic [5:0] c_OP_BNEZ  = 6'b100001;
  localparam logic [5:0] c_OP_J     = 6'b100010;

  logic [31:0] r_rf [0:31];

  logic [5:0]  w_op;
  logic [4:0]  w_fa;
  logic [4:0]  w_fb;
  logic [4:0]  w_fc;
  logic [31:0] w_imm_sx;
  logic        w_nop;
  logic        w_rr;
  logic        w_st;
  logic        w_ld;
  logic        w_ia;
  logic        w_beqz;
  logic        w_bnez;
  logic        w_j;
  logic [31:0] w_rd_fa;
  logic [31:0] w_rd_fb;
  logic [31:0] w_rd_fc;
  logic [31:0] w_br_opnd;
  logic [31:0] w_b;
  logic        w_wen;

  // Read port: r0 is hardwired zero, a same-cycle WB write is bypassed.
  function automatic logic [31:0] f_read(input logic [4:0] a);
    if (a == 5'd0)
      return 32'd0;
    else if (wb_wen && (wb_addr == a))
      return wb_data;
    else
      return r_rf[a];
  endfunction

  always_comb begin
    w_op     = ir_in[31:26];
    w_fa     = ir_in[25:21];
    w_fb     = ir_in[20:16];
    w_fc     = ir_in[15:11];
    w_imm_sx = {{16{ir_in[15]}}, ir_in[15:0]};
    w_nop    = (ir_in == 32'd0);

    w_st   = !w_nop && (w_op == c_OP_STORE);
    w_ld   = !w_nop && (w_op == c_OP_LOAD);
    w_rr   = !w_nop && (w_op[5:4] == 2'b00);
    w_ia   = !w_nop && (w_op[5:4] == 2'b01) && !w_st && !w_ld;
    w_beqz = !w_nop && (w_op == c_OP_BEQZ);
    w_bnez = !w_nop && (w_op == c_OP_BNEZ);
    w_j    = !w_nop && (w_op == c_OP_J);

    w_rd_fa = f_read(w_fa);
    w_rd_fb = f_read(w_fb);
    w_rd_fc = f_read(w_fc);

    // EX result is newer than anything in WB or the file.
    if (ex_wen && (ex_addr == w_fa) && (w_fa != 5'd0))
      w_br_opnd = ex_data;
    else
      w_br_opnd = w_rd_fa;

    cond = !reset && (w_j ||
                      (w_beqz && (w_br_opnd == 32'd0)) ||
                      (w_bnez && (w_br_opnd != 32'd0)));
    rpc  = npc_in + w_imm_sx;

    if (w_rr)
      w_b = w_rd_fc;
    else if (w_st)
      w_b = w_rd_fa;
    else
      w_b = 32'd0;

    w_wen = (w_rr || w_ia || w_ld) && (w_fa != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        r_rf[i] <= 32'd0;
    end else if (wb_wen && (wb_addr != 5'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ir     <= 32'd0;
      id_npc    <= 32'd0;
      id_a      <= 32'd0;
      id_b      <= 32'd0;
      id_imm    <= 32'd0;
      id_dst    <= 5'd0;
      id_wen    <= 1'b0;
      taken_cnt <= 16'd0;
    end else begin
      id_ir     <= ir_in;
      id_npc    <= npc_in;
      id_a      <= w_rd_fb;
      id_b      <= w_b;
      id_imm    <= w_imm_sx;
      id_dst    <= w_wen ? w_fa : 5'd0;
      id_wen    <= w_wen;
      if (cond)
        taken_cnt <= taken_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_branch.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_branch
// Purpose  : Scoreboard bench for decode_branch; a reference model queues the
//            expected ID/EX contents, each scenario compares after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_branch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir_in = '0, npc_in = '0;
  logic        ex_wen = 1'b0;
  logic [4:0]  ex_addr = '0;
  logic [31:0] ex_data = '0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        cond;
  logic [31:0] rpc, id_ir, id_npc, id_a, id_b, id_imm;
  logic [4:0]  id_dst;
  logic        id_wen;
  logic [15:0] taken_cnt;

  decode_branch dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .npc_in(npc_in),
    .ex_wen(ex_wen), .ex_addr(ex_addr), .ex_data(ex_data),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .cond(cond), .rpc(rpc), .id_ir(id_ir), .id_npc(id_npc),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
    .id_dst(id_dst), .id_wen(id_wen), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir, npc, a, b, imm;
    logic [4:0]  dst;
    logic        wen;
    logic [15:0] cnt;
  } idex_t;

  idex_t act, exp_v, dummy;
  assign act = {id_ir, id_npc, id_a, id_b, id_imm, id_dst, id_wen, taken_cnt};

  idex_t       sb[$];
  logic [31:0] m_rf [0:31];
  logic [15:0] m_cnt = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  localparam logic [5:0] OP_RR = 6'h00, OP_ST = 6'h10, OP_LD = 6'h11,
                         OP_IA = 6'h12, OP_BEQZ = 6'h20, OP_BNEZ = 6'h21,
                         OP_J = 6'h22, OP_BAD = 6'h30;

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] fa,
                                      input logic [4:0] fb, input logic [15:0] imm);
    return {op, fa, fb, imm};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic w,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (w && wa == a) return wd;
    return m_rf[a];
  endfunction

  // Drive one cycle of inputs and queue the ID/EX state expected after the edge.
  task automatic drive(input logic rst, input logic [31:0] ir, input logic [31:0] npc,
                       input logic exw, input logic [4:0] exa, input logic [31:0] exd,
                       input logic wbw, input logic [4:0] wba, input logic [31:0] wbd);
    logic [5:0] op; logic [4:0] fa, fb, fc;
    logic nop, rr, st, ld, ia, c;
    logic [31:0] opnd;
    idex_t e;
    reset = rst; ir_in = ir; npc_in = npc;
    ex_wen = exw; ex_addr = exa; ex_data = exd;
    wb_wen = wbw; wb_addr = wba; wb_data = wbd;
    op = ir[31:26]; fa = ir[25:21]; fb = ir[20:16]; fc = ir[15:11];
    nop = (ir == 0);
    st = !nop && op == OP_ST;
    ld = !nop && op == OP_LD;
    rr = !nop && op[5:4] == 2'b00;
    ia = !nop && op[5:4] == 2'b01 && !st && !ld;
    opnd = (exw && exa == fa && fa != 0) ? exd : m_read(fa, wbw, wba, wbd);
    c = !rst && (op == OP_J || (op == OP_BEQZ && opnd == 0) || (op == OP_BNEZ && opnd != 0));
    if (rst) begin
      e = '0;
      m_cnt = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      e.ir  = ir;
      e.npc = npc;
      e.a   = m_read(fb, wbw, wba, wbd);
      e.b   = rr ? m_read(fc, wbw, wba, wbd) : (st ? m_read(fa, wbw, wba, wbd) : 32'd0);
      e.imm = {{16{ir[15]}}, ir[15:0]};
      e.wen = (rr || ia || ld) && fa != 0;
      e.dst = e.wen ? fa : 5'd0;
      m_cnt = m_cnt + {15'd0, c};
      e.cnt = m_cnt;
      if (wbw && wba != 0) m_rf[wba] = wbd;
    end
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    drive(1, ins(OP_J, 0, 0, 16'h0004), 32'h40, 0, 0, 0, 1, 6, 32'hDEAD);
    #1; n_chk++;
    if (cond !== 1'b0) begin n_fail++; $display("FAIL reset_cond: got %b want 0", cond); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || act !== '0) begin n_fail++; $display("FAIL reset_idex: got %h want %h", act, exp_v); end
  endtask

  task automatic test_rr;
    drive(0, 32'd0, 32'h1, 0, 0, 0, 1, 5, 32'h1234);
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin n_fail++; $display("FAIL rr_wb_idex: got %h want %h", act, exp_v); end
    drive(0, ins(OP_RR, 3, 5, 16'h0000), 32'h2, 0, 0, 0, 0, 0, 0);
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || id_a !== 32'h1234 || id_b !== 0 || id_dst !== 3 || id_wen !== 1)
      begin n_fail++; $display("FAIL rr_idex: got %h want %h", act, exp_v); end
    // r6 was written during reset and must read back as zero.
    drive(0, ins(OP_RR, 1, 6, 16'h0000), 32'h3, 0, 0, 0, 0, 0, 0);
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || id_a !== 0) begin n_fail++; $display("FAIL reset_wb_discard: got %h want %h", act, exp_v); end
  endtask

  task automatic test_bypass;
    drive(0, ins(OP_ST, 7, 7, 16'h0008), 32'h4, 0, 0, 0, 1, 7, 32'hAA);
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || id_a !== 32'hAA || id_b !== 32'hAA || id_wen !== 0)
      begin n_fail++; $display("FAIL store_bypass: got %h want %h", act, exp_v); end
  endtask

  task automatic test_beqz;
    drive(0, ins(OP_BEQZ, 2, 0, 16'hFFFC), 32'h10, 0, 0, 0, 0, 0, 0);
    #1; n_chk++;
    if (cond !== 1'b1 || rpc !== 32'h0C) begin n_fail++; $display("FAIL beqz_cond: got %b/%h want 1/0000000c", cond, rpc); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || id_wen !== 0 || taken_cnt !== 16'd1)
      begin n_fail++; $display("FAIL beqz_idex: got %h want %h", act, exp_v); end
    drive(0, ins(OP_BEQZ, 7, 0, 16'h0010), 32'h7FFF_FFF8, 0, 0, 0, 0, 0, 0);
    #1; n_chk++;
    if (cond !== 1'b0) begin n_fail++; $display("FAIL beqz_nottaken: got %b want 0", cond); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin n_fail++; $display("FAIL beqz_nt_idex: got %h want %h", act, exp_v); end
  endtask

  task automatic test_bnez;
    drive(0, ins(OP_BNEZ, 4, 0, 16'h0002), 32'h20, 1, 4, 32'd9, 0, 0, 0);
    #1; n_chk++;
    if (cond !== 1'b1 || rpc !== 32'h22) begin n_fail++; $display("FAIL bnez_exfwd: got %b/%h want 1/00000022", cond, rpc); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin n_fail++; $display("FAIL bnez_idex: got %h want %h", act, exp_v); end
    drive(0, ins(OP_BNEZ, 0, 0, 16'h0002), 32'h21, 1, 0, 32'd9, 0, 0, 0);
    #1; n_chk++;
    if (cond !== 1'b0) begin n_fail++; $display("FAIL bnez_r0_nofwd: got %b want 0", cond); end
    tick; dummy = sb.pop_front();
  endtask

  task automatic test_priority;
    drive(0, 32'd0, 32'h30, 0, 0, 0, 1, 8, 32'd3);
    tick; dummy = sb.pop_front();
    drive(0, ins(OP_BEQZ, 8, 0, 16'h0001), 32'h31, 1, 8, 32'd0, 1, 8, 32'd5);
    #1; n_chk++;
    if (cond !== 1'b1) begin n_fail++; $display("FAIL ex_over_wb: got %b want 1", cond); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin n_fail++; $display("FAIL ex_over_wb_idex: got %h want %h", act, exp_v); end
    drive(0, ins(OP_BEQZ, 8, 0, 16'h0001), 32'h32, 1, 9, 32'd7, 1, 8, 32'd0);
    #1; n_chk++;
    if (cond !== 1'b1) begin n_fail++; $display("FAIL wb_over_file: got %b want 1", cond); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin n_fail++; $display("FAIL wb_over_file_idex: got %h want %h", act, exp_v); end
  endtask

  task automatic test_nop;
    drive(0, 32'd0, 32'h40, 0, 0, 0, 1, 0, 32'hFF);
    #1; n_chk++;
    if (cond !== 1'b0) begin n_fail++; $display("FAIL nop_cond: got %b want 0", cond); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || id_wen !== 0) begin n_fail++; $display("FAIL nop_idex: got %h want %h", act, exp_v); end
    drive(0, ins(OP_BAD, 9, 0, 16'h8000), 32'h41, 1, 0, 32'hFF, 1, 0, 32'hFF);
    #1; n_chk++;
    if (cond !== 1'b0) begin n_fail++; $display("FAIL badop_cond: got %b want 0", cond); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || id_wen !== 0 || id_a !== 0 || id_imm !== 32'hFFFF_8000)
      begin n_fail++; $display("FAIL badop_r0_idex: got %h want %h", act, exp_v); end
  endtask

  task automatic test_load_imm;
    drive(0, ins(OP_LD, 9, 5, 16'hFF80), 32'h50, 0, 0, 0, 0, 0, 0);
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || id_dst !== 9 || id_wen !== 1 || id_b !== 0)
      begin n_fail++; $display("FAIL load_idex: got %h want %h", act, exp_v); end
    drive(0, ins(OP_IA, 0, 7, 16'h0123), 32'h51, 0, 0, 0, 0, 0, 0);
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || id_wen !== 0 || id_dst !== 0)
      begin n_fail++; $display("FAIL imm_fa0_idex: got %h want %h", act, exp_v); end
  endtask

  task automatic test_wrap;
    drive(1, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0);
    tick; dummy = sb.pop_front();
    for (int k = 0; k < 65535; k++) begin
      drive(0, ins(OP_J, 0, 0, 16'h0004), 32'h100, 0, 0, 0, 0, 0, 0);
      tick; dummy = sb.pop_front();
    end
    n_chk++;
    if (taken_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_preset: got %h want ffff", taken_cnt); end
    drive(0, ins(OP_J, 0, 0, 16'h0004), 32'h100, 0, 0, 0, 0, 0, 0);
    #1; n_chk++;
    if (cond !== 1'b1 || rpc !== 32'h104) begin n_fail++; $display("FAIL j_cond: got %b/%h want 1/00000104", cond, rpc); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || taken_cnt !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap: got %h want %h", act, exp_v); end
    drive(1, ins(OP_J, 0, 0, 16'h0004), 32'h100, 0, 0, 0, 0, 0, 0);
    #1; n_chk++;
    if (cond !== 1'b0) begin n_fail++; $display("FAIL reset_j_cond: got %b want 0", cond); end
    tick; exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || act !== '0) begin n_fail++; $display("FAIL reset_j_idex: got %h want %h", act, exp_v); end
  endtask

  initial begin
    test_reset;
    test_rr;
    test_bypass;
    test_beqz;
    test_bnez;
    test_priority;
    test_nop;
    test_load_imm;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_branch.md
DECODE_BRANCH -- requirements
Module: decode_branch

Interface
REQ-001 clk  in  1  clock; all state changes on posedge.
REQ-002 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-003 ir_in  in  32  instruction word from fetch; 0 = bubble/NOP.
REQ-004 npc_in  in  32  word address of ir_in plus 1.
REQ-005 ex_wen, ex_addr, ex_data  in  1/5/32  result being produced in EX this cycle (branch-operand forward).
REQ-006 wb_wen, wb_addr, wb_data  in  1/5/32  register-file write port.
REQ-007 cond  out  1  redirect fetch this cycle.
REQ-008 rpc  out  32  redirect target word address.
REQ-009 id_ir, id_npc  out  32  ID/EX copy of ir_in, npc_in.
REQ-010 id_a, id_b, id_imm  out  32  ID/EX operand A, operand B, sign-extended immediate.
REQ-011 id_dst, id_wen  out  5/1  ID/EX destination register and write enable.
REQ-012 taken_cnt  out  16  count of redirects taken since reset.

Function
REQ-013 Fields: op=ir[31:26], fa=ir[25:21], fb=ir[20:16], fc=ir[15:11], imm=ir[15:0].
REQ-014 Classes: RR-ALU op[5:4]=00; store op=010000; load op=010001; imm-ALU other op[5:4]=01; BEQZ 100000; BNEZ 100001; J 100010; every other op is NOP.
REQ-015 ir_in==0 is NOP regardless of class decode.
REQ-016 Register file: 32x32, r0 reads 0 always; write on posedge when wb_wen=1 and wb_addr!=0.
REQ-017 Read bypass: a read of wb_addr (nonzero) in the cycle wb_wen=1 returns wb_data.
REQ-018 Branch operand = rf[fa] with priority EX forward (ex_wen, ex_addr==fa, fa!=0) > WB bypass > file.
REQ-019 cond combinational: 1 for J; BEQZ when operand==0; BNEZ when operand!=0; else 0.
REQ-020 rpc combinational = npc_in + sign-extended imm, 32-bit modulo 2^32; rpc value is don't-care when cond=0.
REQ-021 cond forced 0 while reset=1.
REQ-022 ID/EX registers load every posedge (no stall input); latency ir_in -> id_* is 1 cycle.
REQ-023 id_a = rf[fb] (WB bypass only, no EX forward).
REQ-024 id_b = rf[fc] for RR-ALU; rf[fa] for store; 0 otherwise.
REQ-025 id_imm = {{16{imm[15]}}, imm} for all classes.
REQ-026 id_dst/id_wen: fa/1 for RR-ALU, imm-ALU, load when fa!=0; 0/0 for store, branches, NOP, or fa==0.
REQ-027 Branches and J pass to id_ir unchanged with id_wen=0; no delay slot, no squash (fetch loads the target on the same edge).
REQ-028 taken_cnt increments by 1 on each posedge where cond=1; wraps 0xFFFF -> 0x0000.
REQ-029 No interlock: a branch whose fa is produced by a load in EX reads the forwarded ex_data as presented; correctness of that case is the producer's responsibility.

Reset
REQ-030 On posedge with reset=1: all 32 registers cleared to 0, id_ir, id_npc, id_a, id_b, id_imm, id_dst = 0, id_wen = 0, taken_cnt = 0.
REQ-031 A wb write requested during the reset cycle is discarded.
REQ-032 First non-reset cycle: ID/EX captures ir_in normally.

Verification
REQ-033 Reset, then wb r5=0x1234; next cycle RR-ALU ir fa=3,fb=5,fc=0 -> after one posedge id_a=0x1234, id_b=0, id_dst=3, id_wen=1.
REQ-034 Same-cycle bypass: wb r7=0xAA while ir_in=store fa=7,fb=7 -> id_a=0xAA, id_b=0xAA, id_wen=0.
REQ-035 BEQZ fa=2 (r2=0), npc_in=0x10, imm=0xFFFC -> cond=1, rpc=0x0C, taken_cnt +1 next edge.
REQ-036 BNEZ fa=4, r4=0 in file, ex_wen=1, ex_addr=4, ex_data=9 -> cond=1 (EX forward beats file).
REQ-037 ir_in=0 and op=110000 -> cond=0, id_wen=0; writes to r0 leave r0 reading 0.
REQ-038 taken_cnt preset via 65535 J cycles, one more J -> 0x0000; assert reset with ir_in=J -> cond=0, all outputs 0.
